// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: UART byte-frame parser driving the register-file bus.
//   Write frame: WR_CMD, addr, data -> one-cycle RF_WrEn.
//   Read frame:  RD_CMD, addr       -> one-cycle RF_RdEn, then the read
//                response is forwarded to the transmitter once it is idle.
// Optional feature macro: CMD_TIMEOUT_EN (read-response timeout that replies
// with 8'hEE and pulses CMD_ERR when the register file never answers).
module reg_cmd_ctrl #(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            ADDR_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0]  WR_CMD         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0]  RD_CMD         = 8'hBB,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic                  RF_WrEn,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  RF_RdEn,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wrdata_nx;
  logic [DATA_WIDTH-1:0] txdata_nx;
  logic                  wren_nx;
  logic                  rden_nx;
  logic                  txvld_nx;
  logic                  err_nx;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned           CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_BYTE = DATA_WIDTH'(8'hEE);

  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  // State and all registered outputs; synchronous reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      RF_Address <= '0;
      RF_WrData  <= '0;
      TX_P_DATA  <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nx;
      RF_Address <= addr_nx;
      RF_WrData  <= wrdata_nx;
      TX_P_DATA  <= txdata_nx;
      RF_WrEn    <= wren_nx;
      RF_RdEn    <= rden_nx;
      TX_D_VLD   <= txvld_nx;
      CMD_ERR    <= err_nx;
`ifdef CMD_TIMEOUT_EN
      cnt        <= cnt_nx;
`endif
    end
  end

  // Next-state and next-output decode; data registers hold unless loaded.
  always_comb begin
    state_nx  = state;
    addr_nx   = RF_Address;
    wrdata_nx = RF_WrData;
    txdata_nx = TX_P_DATA;
    wren_nx   = 1'b0;
    rden_nx   = 1'b0;
    txvld_nx  = 1'b0;
    err_nx    = 1'b0;
`ifdef CMD_TIMEOUT_EN
    cnt_nx    = cnt;
`endif

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_nx = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_nx = RD_ADDR;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wrdata_nx = RX_P_DATA;
          wren_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
          rden_nx  = 1'b1;
          state_nx = RD_WAIT;
`ifdef CMD_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end

      RD_WAIT: begin
        // A stray byte here is dropped and flagged; the read still proceeds.
        if (RX_D_VLD) begin
          err_nx = 1'b1;
        end
        if (RF_RdData_Valid) begin
          txdata_nx = RF_RdData;
          state_nx  = TX_SEND;
        end
`ifdef CMD_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          txdata_nx = TIMEOUT_BYTE;
          err_nx    = 1'b1;
          state_nx  = TX_SEND;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end

      TX_SEND: begin
        if (RX_D_VLD) begin
          err_nx = 1'b1;
        end
        if (!TX_BUSY) begin
          txvld_nx = 1'b1;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: scoreboard bench for reg_cmd_ctrl. A frame-level model
// pushes expected bus events (write, read strobe, transmit, error) in order;
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_reg_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [3:0] rf_addr;
  logic       rf_wren;
  logic [7:0] rf_wrdata;
  logic       rf_rden;
  logic [7:0] rf_rddata;
  logic       rf_rdvld;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_busy;
  logic       cmd_err;

  always #5 clk = ~clk;

  reg_cmd_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .WR_CMD        (8'hAA),
    .RD_CMD        (8'hBB),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .RX_P_DATA      (rx_data),
    .RX_D_VLD       (rx_vld),
    .RF_Address     (rf_addr),
    .RF_WrEn        (rf_wren),
    .RF_WrData      (rf_wrdata),
    .RF_RdEn        (rf_rden),
    .RF_RdData      (rf_rddata),
    .RF_RdData_Valid(rf_rdvld),
    .TX_P_DATA      (tx_data),
    .TX_D_VLD       (tx_vld),
    .TX_BUSY        (tx_busy),
    .CMD_ERR        (cmd_err)
  );

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_TX  = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_mem[16];
  logic [7:0] rf_mem[16];
  logic       rf_mute = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         tx_cnt = 0;

  // Register-file environment: read data one cycle after an accepted RdEn.
  always @(posedge clk) begin
    rf_rdvld <= 1'b0;
    if (rf_wren) rf_mem[rf_addr] <= rf_wrdata;
    if (rf_rden && !rf_mute) begin
      rf_rdvld  <= 1'b1;
      rf_rddata <= rf_mem[rf_addr];
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d a=%02h d=%02h expected none at %0t",
               kind, a, d, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.d !== d) begin
        errors++;
        $display("FAIL event: got kind=%0d a=%02h d=%02h expected kind=%0d a=%02h d=%02h at %0t",
                 kind, a, d, e.kind, e.a, e.d, $time);
      end
    end
  endtask

  // Monitor: compares every output pulse against the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wren || rf_rden) check("wren_rden_exclusive", {7'd0, rf_wren & rf_rden}, 8'h00);
      if (rf_wren) pop_cmp(K_WR, {4'd0, rf_addr}, rf_wrdata);
      if (rf_rden) pop_cmp(K_RD, {4'd0, rf_addr}, 8'h00);
      if (cmd_err) pop_cmp(K_ERR, 8'h00, 8'h00);
      if (tx_vld) begin
        pop_cmp(K_TX, 8'h00, tx_data);
        tx_cnt++;
      end
    end
  end

  function automatic ev_t mk(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int start);
    for (int i = 0; i < 80 && tx_cnt == start; i++) @(negedge clk);
    check("tx_wait", {7'd0, tx_cnt != start}, 8'h01);
  endtask

  task automatic wr_frame(input logic [7:0] ab, input logic [7:0] db, input int g);
    model_mem[ab[3:0]] = db;
    exp_q.push_back(mk(K_WR, {4'd0, ab[3:0]}, db));
    send_byte(8'hAA); gap(g);
    send_byte(ab);    gap(g);
    send_byte(db);
  endtask

  task automatic rd_frame(input logic [7:0] ab, input int busy, input int g);
    int start;
    start = tx_cnt;
    exp_q.push_back(mk(K_RD, {4'd0, ab[3:0]}, 8'h00));
    exp_q.push_back(mk(K_TX, 8'h00, model_mem[ab[3:0]]));
    tx_busy = (busy > 0);
    send_byte(8'hBB); gap(g);
    send_byte(ab);
    gap(busy);
    tx_busy = 1'b0;
    wait_tx(start);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},   {4'd0, rf_addr}, 8'h00);
    check({tag, "_wren"},   {7'd0, rf_wren}, 8'h00);
    check({tag, "_wrdata"}, rf_wrdata,       8'h00);
    check({tag, "_rden"},   {7'd0, rf_rden}, 8'h00);
    check({tag, "_txdata"}, tx_data,         8'h00);
    check({tag, "_txvld"},  {7'd0, tx_vld},  8'h00);
    check({tag, "_err"},    {7'd0, cmd_err}, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int         start;
    int         n;

    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'(i * 7 + 1);
      rf_mem[i]    = 8'(i * 7 + 1);
    end
    model_mem[2] = 8'h81; rf_mem[2] = 8'h81;
    model_mem[3] = 8'h20; rf_mem[3] = 8'h20;

    rst = 1'b1; rx_vld = 1'b0; rx_data = '0; tx_busy = 1'b0;
    gap(3);
    check_all_zero("reset");
    rst = 1'b0;
    gap(1);

    // Write frame: strobe lands the cycle after the data byte.
    wr_frame(8'h05, 8'h3C, 0);
    check("wr_latency", {7'd0, rf_wren}, 8'h01);
    gap(1);
    check("wr_single_pulse", {7'd0, rf_wren}, 8'h00);
    gap(2);

    // Read with idle transmitter.
    rd_frame(8'h02, 0, 0);
    gap(2);

    // Read with transmitter busy; a stray byte during the read is flagged.
    tx_busy = 1'b1;
    start   = tx_cnt;
    exp_q.push_back(mk(K_RD, 8'h03, 8'h00));
    exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
    exp_q.push_back(mk(K_TX, 8'h00, 8'h20));
    send_byte(8'hBB);
    send_byte(8'h03);
    send_byte(8'h12);
    for (int i = 0; i < 10; i++) begin
      check("tx_held_while_busy", {7'd0, tx_vld}, 8'h00);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    check("tx_after_busy", {7'd0, tx_vld}, 8'h01);
    @(negedge clk);
    check("tx_single_pulse", {7'd0, tx_vld}, 8'h00);
    check("tx_count", 8'(tx_cnt - start), 8'h01);
    gap(2);

    // Bad opcode then a write with an over-range address byte.
    exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
    send_byte(8'h55);
    check("err_pulse", {7'd0, cmd_err}, 8'h01);
    @(negedge clk);
    check("err_single_pulse", {7'd0, cmd_err}, 8'h00);
    wr_frame(8'h1F, 8'hC7, 0);
    check("wr_trunc_addr", {4'd0, rf_addr}, 8'h0F);
    gap(2);

    // Reset mid-frame discards the partial write.
    send_byte(8'hAA);
    send_byte(8'h04);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
    send_byte(8'hC7);
    check("post_reset_no_wren", {7'd0, rf_wren}, 8'h00);
    check("post_reset_err", {7'd0, cmd_err}, 8'h01);
    gap(2);

`ifdef CMD_TIMEOUT_EN
    // Register file never answers: timeout reply after 16 cycles in RD_WAIT.
    rf_mute = 1'b1;
    start   = tx_cnt;
    exp_q.push_back(mk(K_RD, 8'h01, 8'h00));
    exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
    exp_q.push_back(mk(K_TX, 8'h00, 8'hEE));
    send_byte(8'hBB);
    send_byte(8'h01);
    n = 0;
    while (!cmd_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 8'(n), 8'd16);
    wait_tx(start);
    rf_mute = 1'b0;
    gap(2);
`endif

    // Randomized frames with back-to-back and gapped bytes.
    for (int f = 0; f < 150; f++) begin
      case ($urandom_range(0, 3))
        0, 1: wr_frame(8'($urandom), 8'($urandom), $urandom_range(0, 2));
        2:    rd_frame(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
        default: begin
          b = 8'($urandom);
          if (b == 8'hAA || b == 8'hBB) b = 8'h00;
          exp_q.push_back(mk(K_ERR, 8'h00, 8'h00));
          send_byte(b);
        end
      endcase
      gap($urandom_range(0, 2));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    gap(2);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
